// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, flag indices, sequencer state and command record.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_CARRY = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
    logic       wr_acc;
  } cmd_t;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU and result buses of the sequencer.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic       cmd_wr_acc;
  logic       flush;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_res;
  logic [2:0] out_flags;
  logic [3:0] acc;
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_wr_acc, flush,
    input  alu_res, alu_zero, alu_overflow, alu_carry, out_ready,
    output cmd_ready, alu_fnselec, alu_a, alu_b, out_valid, out_res, out_flags, acc
  );
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_wr_acc, flush,
    output alu_res, alu_zero, alu_overflow, alu_carry, out_ready,
    input  cmd_ready, alu_fnselec, alu_a, alu_b, out_valid, out_res, out_flags, acc
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: command FIFO; no bypass, full refuses pushes even when popping.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);
  cmd_t mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (PTR_W+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full && !flush;
    do_pop = pop && !empty && !flush;
    wr_d = flush ? '0 : do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d = flush ? '0 : do_pop ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = flush ? '0 : cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    dout = mem_q[rd_q];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues one at a time and returns results over valid/ready.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic clk,
  input logic rst,
  alu_cmd_sequencer_if.slave bus
);
  cmd_t din, head;
  logic full, empty, issue, capture;
  state_t state_q, state_d;
  logic [2:0] fn_q, fn_d, flags_q, flags_d;
  logic [3:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic wr_acc_q, wr_acc_d;
  assign din = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_use_acc, bus.cmd_wr_acc};
  alu_cmd_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk(clk), .rst(rst), .push(bus.cmd_valid), .pop(issue), .flush(bus.flush),
    .din(din), .dout(head), .full(full), .empty(empty)
  );
  // acc is read at the pop edge, so a back-to-back use_acc sees the previous write
  always_comb begin
    issue = !bus.flush && !empty && (state_q == IDLE || (state_q == DONE && bus.out_ready));
    capture = !bus.flush && state_q == EXEC;
    state_d = bus.flush ? IDLE : issue ? EXEC : capture ? DONE :
              (state_q == DONE && bus.out_ready) ? IDLE : state_q;
    fn_d = issue ? head.op : fn_q;
    a_d = issue ? (head.use_acc ? acc_q : head.a) : a_q;
    b_d = issue ? head.b : b_q;
    wr_acc_d = issue ? head.wr_acc : wr_acc_q;
    res_d = capture ? bus.alu_res : res_q;
    flags_d = capture ? {bus.alu_carry, bus.alu_overflow, bus.alu_zero} : flags_q;
    acc_d = (capture && wr_acc_q) ? bus.alu_res : acc_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      fn_q <= '0;
      a_q <= '0;
      b_q <= '0;
      wr_acc_q <= 1'b0;
      res_q <= '0;
      flags_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      fn_q <= fn_d;
      a_q <= a_d;
      b_q <= b_d;
      wr_acc_q <= wr_acc_d;
      res_q <= res_d;
      flags_q <= flags_d;
      acc_q <= acc_d;
    end
  assign bus.cmd_ready = !full;
  assign bus.alu_fnselec = fn_q;
  assign bus.alu_a = a_q;
  assign bus.alu_b = b_q;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_res = res_q;
  assign bus.out_flags = flags_q;
  assign bus.acc = acc_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with a behavioural ALU and accumulator model.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_cmd_sequencer_if bus();
  alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic [2:0] flags;
    logic [3:0] acc;
  } exp_t;
  exp_t exp_q[$];
  int hs_cyc[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [3:0] pred_acc = '0;
  logic [3:0] comm_acc = '0;
  logic [6:0] alu_o, e;

  // returns {carry, overflow, zero, res}
  function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_LT:  r = {3'b000, $signed(a) < $signed(b)};
      default: r = {3'b000, a == b};
    endcase
    return {c, v, r == 4'd0, r};
  endfunction

  always_comb alu_o = alu_ref(bus.alu_fnselec, bus.alu_a, bus.alu_b);
  assign bus.alu_res = alu_o[3:0];
  assign bus.alu_zero = alu_o[4];
  assign bus.alu_overflow = alu_o[5];
  assign bus.alu_carry = alu_o[6];

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          chk("out_res", bus.out_res, exp_q[0].res);
          chk("out_flags", bus.out_flags, exp_q[0].flags);
          chk("acc_at_result", bus.acc, exp_q[0].acc);
          if (bus.out_ready) begin
            comm_acc = exp_q[0].acc;
            void'(exp_q.pop_front());
            hs_cyc.push_back(cyc);
          end
        end
      end
      if (bus.flush) begin
        exp_q.delete();
        pred_acc = comm_acc;
      end else if (bus.cmd_valid && bus.cmd_ready) begin
        e = alu_ref(bus.cmd_op, bus.cmd_use_acc ? pred_acc : bus.cmd_a, bus.cmd_b);
        if (bus.cmd_wr_acc) pred_acc = e[3:0];
        exp_q.push_back('{e[3:0], e[6:4], pred_acc});
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua, input logic wa);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    bus.cmd_use_acc = ua; bus.cmd_wr_acc = wa;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("valid_timeout", 1, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int rdy_cnt, sent, n;
    logic last_rdy;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_a = 0; bus.cmd_b = 0;
    bus.cmd_use_acc = 0; bus.cmd_wr_acc = 0; bus.flush = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_acc", bus.acc, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_fnselec", bus.alu_fnselec, 0);
    chk("rst_out_res", bus.out_res, 0);
    chk("rst_out_flags", bus.out_flags, 0);
    @(posedge clk); #1;

    // single add: valid appears after the third edge counting the push edge
    bus.out_ready = 1'b1;
    send(OP_ADD, 4'd7, 4'd9, 1'b0, 1'b0);
    @(negedge clk); chk("lat_edge1", bus.out_valid, 0);
    @(negedge clk); chk("lat_edge2", bus.out_valid, 0);
    @(negedge clk); chk("lat_edge3", bus.out_valid, 1);
    chk("add_res", bus.out_res, 0);
    chk("add_carry", bus.out_flags[FLAG_CARRY], 1);
    chk("add_acc", bus.acc, 0);
    drain();

    // accumulator chain
    hs_cyc.delete();
    send(OP_ADD, 4'd3, 4'd4, 1'b0, 1'b1);
    send(OP_ADD, 4'd0, 4'd5, 1'b1, 1'b1);
    drain();
    chk("chain_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) chk("chain_spacing", hs_cyc[1] - hs_cyc[0], 2);
    chk("chain_acc", bus.acc, 12);

    // backpressure: one result stalled in DONE, then fill the FIFO
    bus.out_ready = 1'b0;
    send(OP_XOR, 4'd5, 4'd3, 1'b0, 1'b0);
    wait_valid();
    @(posedge clk); #1;
    rdy_cnt = 0; last_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'($urandom_range(7)); bus.cmd_a = 4'($urandom);
      bus.cmd_b = 4'($urandom); bus.cmd_use_acc = 1'($urandom); bus.cmd_wr_acc = 1'b0;
      @(negedge clk);
      if (bus.cmd_ready) rdy_cnt++;
      last_rdy = bus.cmd_ready;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", rdy_cnt, 4);
    chk("bp_fifth_ready", last_rdy, 0);
    repeat (3) @(posedge clk);
    #1 drain();

    // flush while a command executes with two more queued
    bus.out_ready = 1'b0;
    send(OP_ADD, 4'd1, 4'd1, 1'b0, 1'b0);
    send(OP_ADD, 4'd1, 4'd2, 1'b0, 1'b1);
    send(OP_SUB, 4'd9, 4'd2, 1'b0, 1'b1);
    send(OP_OR, 4'd8, 4'd1, 1'b0, 1'b1);
    wait_valid();
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0; bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("flush_out_valid", bus.out_valid, 0);
    end
    chk("flush_cmd_ready", bus.cmd_ready, 1);
    chk("flush_acc", bus.acc, 12);
    @(posedge clk); #1;
    send(OP_ADD, 4'd2, 4'd2, 1'b0, 1'b0);
    drain();

    // random traffic across pointer wrap
    sent = 0; n = 0;
    while (sent < 10 && n < 500) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'($urandom_range(7)); bus.cmd_a = 4'($urandom);
      bus.cmd_b = 4'($urandom); bus.cmd_use_acc = 1'($urandom); bus.cmd_wr_acc = 1'($urandom);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      if (bus.cmd_ready) sent++;
      @(posedge clk); #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    chk("wrap_sent", sent, 10);
    drain();
    chk("wrap_acc", bus.acc, pred_acc);

    // asynchronous reset while a result is presented
    bus.out_ready = 1'b0;
    send(OP_ADD, 4'd6, 4'd6, 1'b0, 1'b1);
    wait_valid();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_acc", bus.acc, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    exp_q.delete(); pred_acc = '0; comm_acc = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 4-bit combinational ALU (alu_4bit).
- Buffers ALU commands in a small FIFO and issues one at a time on registered operand lines.
- Captures the ALU result and flags one cycle after issue, and presents them on a valid/ready output port.
- Holds a 4-bit accumulator that can replace operand A, so chained operations run without the host re-sending results.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  3  ALU function code, passed to alu_fnselec.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_use_acc  in  1  replace operand A with the accumulator.
- cmd_wr_acc  in  1  write the result into the accumulator on completion.
- flush  in  1  synchronous drop of queued and in-flight work.
- alu_fnselec  out  3  to the ALU.
- alu_a  out  4  to the ALU.
- alu_b  out  4  to the ALU.
- alu_res  in  4  from the ALU.
- alu_zero  in  1  from the ALU.
- alu_overflow  in  1  from the ALU.
- alu_carry  in  1  from the ALU.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_res  out  4  captured result.
- out_flags  out  3  captured flags, ordered {carry, overflow, zero}.
- acc  out  4  current accumulator value.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - FIFO is emptied and pointers and count are cleared.
  - FSM enters IDLE.
  - acc, alu_fnselec, alu_a, alu_b, out_res and out_flags are all 0.
  - out_valid is 0; cmd_ready is 1 from the first edge after deassert.
- FIFO:
  - cmd_ready = (count != DEPTH).
  - A push happens when cmd_valid && cmd_ready.
  - When full, a push is refused even if a pop occurs in the same cycle; there is no full-pop bypass.
  - There is no empty bypass: a command pushed at edge N can issue at edge N+1 at the earliest.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head at the edge and go to EXEC.
    - Load alu_fnselec=op and alu_b=b.
    - Load alu_a = use_acc ? acc : a, using the acc value at that edge.
    - Latch wr_acc internally.
  - EXEC: the ALU output settles combinationally. At the next edge:
    - capture out_res=alu_res and out_flags;
    - if wr_acc is latched, set acc=alu_res;
    - go to DONE.
  - DONE: out_valid=1; out_res and out_flags are held stable while out_valid && !out_ready.
    - On out_ready with the FIFO not empty: pop the next command at the same edge and go to EXEC (back-to-back issue).
    - On out_ready with the FIFO empty: go to IDLE.
- Timing: issue-to-valid latency is 2 edges after the pop edge. Sustained throughput is one result every 2 cycles.
- Dependencies: a use_acc command issued back-to-back sees the acc value written by the previous command, because the acc write precedes the pop edge by at least one cycle.
- ALU operand lines keep their last values in IDLE and DONE.
- Function codes the ALU leaves unimplemented are not filtered. Whatever the ALU drives is captured verbatim; the sequencer does no op decoding.
- flush (synchronous, highest priority after reset):
  - empties the FIFO;
  - the FSM goes to IDLE and out_valid drops;
  - an EXEC result is discarded and acc is not written;
  - acc keeps its value.
- flush with cmd_valid in the same cycle: the push is dropped.
- rst in any state aborts immediately, with no partial acc update.

Decomposition:
- Shared package alu_pkg:
  - ALU op encodings ADD=000, SUB=001, NOT=010, AND=011, OR=100, XOR=101, LT=110, EQ=111.
  - Flag bit indices FLAG_ZERO=0, FLAG_OVF=1, FLAG_CARRY=2.
  - FSM state encoding IDLE=2'd0, EXEC=2'd1, DONE=2'd2.
  - Command record layout: op, a, b, use_acc, wr_acc = 13 bits.
- One sub-module: alu_cmd_fifo (parameterised DEPTH, 13-bit width, push/pop/flush/full/empty).

Test Plan:
- Reset check: assert rst mid-DONE with out_valid=1 → out_valid=0, acc=0, cmd_ready=1 asynchronously, before the next edge.
- Single add: cmd op=000 a=7 b=9 wr_acc=0, out_ready=1 → out_valid exactly 3 edges after push; out_res=0, out_flags={carry=1, ovf=X as driven, zero as driven}; acc=0.
- Accumulator chain, out_ready held 1:
  - cmd1 op=000 a=3 b=4 wr_acc=1;
  - cmd2 op=000 use_acc=1 b=5 wr_acc=1;
  - → results 7 then 12, acc=12, results 2 cycles apart.
- Backpressure: push 5 commands with out_ready=0 → 4 accepted, cmd_ready=0 on the 5th. The first result is held stable while stalled. Releasing out_ready drains all 4 in order.
- Flush: flush during EXEC with 2 commands queued → out_valid never rises, FIFO empty, acc unchanged (e.g. stays 12).
- Wrap-around: 10 sequential commands with random op/a/b and out_ready toggling → output order and values match the scoreboard across pointer wrap.
